// File: rtl/cmac_pkg.sv
// Shared types and helpers for the CMAC RX packet FIFO.
package cmac_pkg;

   localparam int STAT_WIDTH = 32;

   typedef enum logic [2:0] {
      DROP_NONE     = 3'd0,
      DROP_ERR      = 3'd1,
      DROP_OVF      = 3'd2,
      DROP_OVERSIZE = 3'd3,
      DROP_LINK     = 3'd4
   } drop_reason_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FRAME   = 2'd1,
      DISCARD = 2'd2
   } wr_state_t;

   function automatic int keep_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/cmac_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module cmac_sdp_ram #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cmac_rx_packet_fifo.sv
// Store-and-forward AXIS packet FIFO for CMAC RX: forwards only complete, good frames.
// drop_reason is 3 bits wide so every drop_reason_t code, including DROP_LINK, is representable.
//
// state   | meaning
// IDLE    | between frames; next accepted beat starts a frame
// FRAME   | frame in progress, beats written speculatively past wr_commit
// DISCARD | frame already dropped; swallow beats up to and including tlast
module cmac_rx_packet_fifo
   import cmac_pkg::*;
#(
   parameter int DATA_WIDTH      = 512,
   parameter int DEPTH           = 256,
   parameter int MAX_FRAME_BEATS = 160,
   parameter bit DROP_ON_ERROR   = 1'b1
) (
   input  logic                          cmac_clk,
   input  logic                          cmac_reset,
   input  logic                          link_up,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic [keep_width(DATA_WIDTH)-1:0] s_axis_tkeep,
   input  logic                          s_axis_tuser,
   input  logic                          s_axis_tlast,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [keep_width(DATA_WIDTH)-1:0] m_axis_tkeep,
   output logic                          m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [STAT_WIDTH-1:0]         frames_good,
   output logic [STAT_WIDTH-1:0]         frames_dropped,
   output logic                          drop_pulse,
   output logic [2:0]                    drop_reason
);

   localparam int KW = keep_width(DATA_WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int RW = DATA_WIDTH + KW + 2;
   localparam int BW = $clog2(MAX_FRAME_BEATS + 1);

   wr_state_t      state, state_nxt;
   logic [PW-1:0]  wr_ptr, wr_ptr_nxt, wr_commit, wr_commit_nxt, rd_ptr;
   logic [BW-1:0]  beats_left, beats_left_nxt;
   logic           beat, full, wr_en, drop, good;
   drop_reason_t   drop_rsn;

   logic           rd_en, ram_vld, skid_valid, out_load, pop;
   logic [1:0]     held;
   logic [RW-1:0]  wr_word, ram_dout, skid_word, out_word;

   assign s_axis_tready = 1'b1;
   assign beat          = s_axis_tvalid & link_up;
   assign full          = (wr_ptr - rd_ptr) == PW'(DEPTH);
   assign wr_word       = {s_axis_tuser & s_axis_tlast, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

   always_ff @(posedge cmac_clk or posedge cmac_reset) begin
      if (cmac_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   // beats_left is a down-counter of remaining beat budget; zero on a new beat means oversize.
   always_comb begin
      state_nxt      = state;
      wr_ptr_nxt     = wr_ptr;
      wr_commit_nxt  = wr_commit;
      beats_left_nxt = beats_left;
      wr_en          = 1'b0;
      drop           = 1'b0;
      good           = 1'b0;
      drop_rsn       = DROP_NONE;
      case (state)
         IDLE, FRAME: begin
            if (state == FRAME && !link_up) begin
               drop       = 1'b1;
               drop_rsn   = DROP_LINK;
               wr_ptr_nxt = wr_commit;
               state_nxt  = DISCARD;
            end else if (beat) begin
               if (full || (state == FRAME && beats_left == '0)) begin
                  drop       = 1'b1;
                  drop_rsn   = full ? DROP_OVF : DROP_OVERSIZE;
                  wr_ptr_nxt = wr_commit;
                  state_nxt  = s_axis_tlast ? IDLE : DISCARD;
               end else if (s_axis_tlast) begin
                  state_nxt = IDLE;
                  if (s_axis_tuser && DROP_ON_ERROR) begin
                     drop       = 1'b1;
                     drop_rsn   = DROP_ERR;
                     wr_ptr_nxt = wr_commit;
                  end else begin
                     wr_en         = 1'b1;
                     wr_ptr_nxt    = wr_ptr + PW'(1);
                     wr_commit_nxt = wr_ptr + PW'(1);
                     good          = 1'b1;
                  end
               end else begin
                  wr_en          = 1'b1;
                  wr_ptr_nxt     = wr_ptr + PW'(1);
                  state_nxt      = FRAME;
                  beats_left_nxt = (state == IDLE) ? BW'(MAX_FRAME_BEATS - 1) : beats_left - BW'(1);
               end
            end
         end
         DISCARD: begin
            if (beat && s_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge cmac_clk or posedge cmac_reset) begin
      if (cmac_reset) begin
         wr_ptr         <= '0;
         wr_commit      <= '0;
         beats_left     <= '0;
         drop_pulse     <= 1'b0;
         drop_reason    <= DROP_NONE;
         frames_good    <= '0;
         frames_dropped <= '0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         wr_commit  <= wr_commit_nxt;
         beats_left <= beats_left_nxt;
         drop_pulse <= drop;
         if (drop) begin
            drop_reason <= drop_rsn;
            if (frames_dropped != '1) frames_dropped <= frames_dropped + STAT_WIDTH'(1);
         end
         if (good && frames_good != '1) frames_good <= frames_good + STAT_WIDTH'(1);
      end
   end

   cmac_sdp_ram #(
      .WIDTH      (RW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk     (cmac_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_word),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (ram_dout)
   );

   // Output register plus one skid entry absorb the read in flight, so reads may
   // only be issued while at most one beat would be held after this cycle.
   assign pop      = m_axis_tvalid & m_axis_tready;
   assign held     = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(ram_vld) - 2'(pop);
   assign rd_en    = (rd_ptr != wr_commit) && (held <= 2'd1);
   assign out_load = !m_axis_tvalid || pop;

   always_ff @(posedge cmac_clk or posedge cmac_reset) begin
      if (cmac_reset) begin
         rd_ptr        <= '0;
         ram_vld       <= 1'b0;
         skid_valid    <= 1'b0;
         skid_word     <= '0;
         out_word      <= '0;
         m_axis_tvalid <= 1'b0;
      end else begin
         ram_vld <= rd_en;
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         if (out_load) begin
            if (skid_valid) begin
               out_word      <= skid_word;
               m_axis_tvalid <= 1'b1;
            end else if (ram_vld) begin
               out_word      <= ram_dout;
               m_axis_tvalid <= 1'b1;
            end else begin
               m_axis_tvalid <= 1'b0;
            end
         end
         if (skid_valid) begin
            if (out_load) begin
               skid_valid <= ram_vld;
               skid_word  <= ram_dout;
            end
         end else if (!out_load && ram_vld) begin
            skid_valid <= 1'b1;
            skid_word  <= ram_dout;
         end
      end
   end

   assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word;

endmodule

// File: tb/tb_cmac_rx_packet_fifo.sv
// Randomized bench for cmac_rx_packet_fifo with a frame-level queue model and directed corner cases.
module tb_cmac_rx_packet_fifo;
   import cmac_pkg::*;

   localparam int DW    = 32;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int MAXB  = 12;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic          u;
   } beat_t;

   logic          cmac_clk = 1'b0;
   logic          cmac_reset;
   logic          link_up;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic [31:0]   frames_good, frames_dropped;
   logic          drop_pulse;
   logic [2:0]    drop_reason;

   int checks = 0;
   int failures = 0;
   int ready_mode = 1;
   int exp_good = 0;
   int exp_dropped = 0;
   beat_t exp_q[$];
   drop_reason_t exp_drop_q[$];

   cmac_rx_packet_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_FRAME_BEATS(MAXB), .DROP_ON_ERROR(1'b1)
   ) dut (
      .cmac_clk(cmac_clk), .cmac_reset(cmac_reset), .link_up(link_up),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .frames_good(frames_good), .frames_dropped(frames_dropped),
      .drop_pulse(drop_pulse), .drop_reason(drop_reason)
   );

   always #5 cmac_clk = ~cmac_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge cmac_clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         tick();
         case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Output checker: every accepted beat against the model queue, AXIS hold rules, drop reasons.
   initial begin
      bit    prev_stall;
      beat_t prev_b, got, e;
      prev_stall = 1'b0;
      prev_b = '0;
      forever begin
         @(negedge cmac_clk);
         if (cmac_reset) begin
            prev_stall = 1'b0;
            continue;
         end
         got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
         if (prev_stall) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_word", got, prev_b);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%0h expected=none", got);
            end else begin
               e = exp_q.pop_front();
               chk("out_beat", got, e);
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_b = got;
         if (drop_pulse) begin
            if (exp_drop_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_drop actual_reason=%0d expected=none", drop_reason);
            end else begin
               chk("drop_reason_seq", drop_reason, exp_drop_q.pop_front());
            end
         end
      end
   end

   // cut: beat index sent with link_up low (0 = none); ovf_at: beat where storage is known full.
   task automatic send_frame(input int len, input bit err, input int cut, input int ovf_at, input bit rnd);
      beat_t        fr[$];
      beat_t        b;
      bit           dropped;
      drop_reason_t rsn;
      int           n;
      dropped = 1'b0;
      rsn = DROP_NONE;
      if (rnd) begin
         n = 0;
         while (exp_q.size() + len > DEPTH && n < 3000) begin
            tick();
            n++;
         end
         if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL space_wait_timeout pending=%0d required<=%0d", exp_q.size(), DEPTH - len);
         end
      end
      for (int i = 1; i <= len; i++) begin
         if (dropped) break;
         if (i == cut) begin
            dropped = 1'b1;
            rsn = DROP_LINK;
         end else if (i == ovf_at) begin
            dropped = 1'b1;
            rsn = DROP_OVF;
         end else if (i > MAXB) begin
            dropped = 1'b1;
            rsn = DROP_OVERSIZE;
         end
      end
      if (!dropped && err) begin
         dropped = 1'b1;
         rsn = DROP_ERR;
      end
      for (int i = 1; i <= len; i++) begin
         b.d = $urandom;
         b.k = KW'($urandom);
         b.l = (i == len);
         b.u = 1'b0;
         fr.push_back(b);
      end
      if (dropped) begin
         exp_drop_q.push_back(rsn);
         exp_dropped++;
      end else begin
         foreach (fr[i]) exp_q.push_back(fr[i]);
         exp_good++;
      end
      for (int i = 1; i <= len; i++) begin
         if (rnd && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata = $urandom;
            tick();
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata = fr[i-1].d;
         s_axis_tkeep = fr[i-1].k;
         s_axis_tlast = (i == len);
         s_axis_tuser = (i == len) ? err : 1'($urandom_range(0, 1));
         link_up = (i != cut);
         tick();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      s_axis_tuser = 1'b0;
      link_up = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      chk("drain_remaining", exp_q.size(), 0);
      repeat (4) @(posedge cmac_clk);
      #1;
   endtask

   initial begin
      int k;
      cmac_reset = 1'b1;
      link_up = 1'b1;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      s_axis_tuser = 1'b0;
      s_axis_tlast = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (3) tick();
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_good", frames_good, 0);
      chk("rst_dropped", frames_dropped, 0);
      chk("rst_reason", drop_reason, DROP_NONE);
      chk("rst_pulse", drop_pulse, 0);
      cmac_reset = 1'b0;
      tick();
      chk("tready_tied", s_axis_tready, 1);

      // 4-beat good frame, first output two edges after tlast accepted
      ready_mode = 1;
      send_frame(4, 1'b0, 0, 0, 1'b0);
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (m_axis_tvalid) begin
            k = i;
            break;
         end
      end
      chk("first_valid_latency", k, 2);
      drain();
      chk("good_after_4beat", frames_good, 1);

      // errored 3-beat frame
      send_frame(3, 1'b1, 0, 0, 1'b0);
      chk("err_pulse_hi", drop_pulse, 1);
      chk("err_reason", drop_reason, DROP_ERR);
      chk("err_dropped", frames_dropped, 1);
      tick();
      chk("err_pulse_lo", drop_pulse, 0);
      drain();

      // overflow with downstream stalled
      ready_mode = 0;
      tick();
      send_frame(10, 1'b0, 0, 0, 1'b0);
      send_frame(10, 1'b0, 0, 9, 1'b0);
      tick();
      chk("ovf_reason", drop_reason, DROP_OVF);
      chk("ovf_good", frames_good, 2);
      chk("ovf_dropped", frames_dropped, 2);
      chk("ovf_stalled_valid", m_axis_tvalid, 1);
      ready_mode = 1;
      drain();

      // oversize boundary: 13 beats dropped, 12 and 2 beats delivered
      send_frame(13, 1'b0, 0, 0, 1'b0);
      send_frame(MAXB, 1'b0, 0, 0, 1'b0);
      send_frame(2, 1'b0, 0, 0, 1'b0);
      drain();
      chk("oversize_reason", drop_reason, DROP_OVERSIZE);
      chk("oversize_good", frames_good, 4);
      chk("oversize_dropped", frames_dropped, 3);

      // link loss in the middle of a frame
      send_frame(6, 1'b0, 3, 0, 1'b0);
      send_frame(1, 1'b0, 0, 0, 1'b0);
      drain();
      chk("link_reason", drop_reason, DROP_LINK);
      chk("link_good", frames_good, 5);
      chk("link_dropped", frames_dropped, 4);

      // reset in the middle of output
      send_frame(8, 1'b0, 0, 0, 1'b0);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (m_axis_tvalid) begin
            k = i;
            break;
         end
      end
      chk("pre_reset_valid_seen", (k != 0), 1);
      tick();
      tick();
      cmac_reset = 1'b1;
      exp_q.delete();
      exp_drop_q.delete();
      exp_good = 0;
      exp_dropped = 0;
      #1;
      chk("reset_tvalid_async", m_axis_tvalid, 0);
      chk("reset_good", frames_good, 0);
      chk("reset_dropped", frames_dropped, 0);
      tick();
      tick();
      cmac_reset = 1'b0;
      tick();
      send_frame(3, 1'b0, 0, 0, 1'b0);
      drain();
      chk("post_reset_good", frames_good, 1);
      chk("post_reset_dropped", frames_dropped, 0);

      // randomized traffic
      ready_mode = 2;
      for (int f = 0; f < 200; f++) begin
         int len;
         int cut;
         bit err;
         len = $urandom_range(1, MAXB + 2);
         err = ($urandom_range(0, 5) == 0);
         cut = 0;
         if (len >= 3 && $urandom_range(0, 7) == 0) cut = $urandom_range(2, len - 1);
         if ($urandom_range(0, 7) == 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tlast = 1'b1;
            s_axis_tdata = $urandom;
            link_up = 1'b0;
            tick();
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            link_up = 1'b1;
         end
         send_frame(len, err, cut, 0, 1'b1);
      end
      drain();
      chk("rand_good", frames_good, exp_good);
      chk("rand_dropped", frames_dropped, exp_dropped);
      chk("rand_drops_left", exp_drop_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
